// File: rtl/tdm_demux16_pkg.sv
// Shared constants, state encoding and slot decode helper for the 16-channel TDM receive path.
package tdm_demux16_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One-hot decode of a slot index into a channel-wide strobe vector.
    function automatic logic [N_CH-1:0] slot_onehot(input logic [SEL_W-1:0] sel);
        logic [N_CH-1:0] vec;
        vec      = {N_CH{1'b0}};
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/tdm_demux16_demux_1x16.sv
// Combinational slot decoder: turns the current slot index into per-channel capture strobes.
module demux_1x16
    import tdm_demux16_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [N_CH-1:0]  we
);

    // Strobe exactly one channel when enabled, none otherwise.
    always_comb begin
        we = {N_CH{1'b0}};
        if (en) begin
            we = slot_onehot(sel);
        end else begin
            we = {N_CH{1'b0}};
        end
    end

endmodule

// File: rtl/tdm_demux16.sv
// Receive end of a 16:1 TDM link: locks to frame_sync, flywheels between syncs and
// presents each completed 16-bit frame in parallel with a one-cycle valid pulse.
module tdm_demux16
    import tdm_demux16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             din,
    input  logic             frame_sync,
    output logic [N_CH-1:0]  dout,
    output logic             dout_valid,
    output logic [SEL_W-1:0] slot,
    output logic             locked,
    output logic             sync_err
);

    state_t           state_r;
    state_t           state_s;
    logic [SEL_W-1:0] slot_r;
    logic [SEL_W-1:0] slot_s;
    logic [N_CH-2:0]  cap_r;
    logic [N_CH-1:0]  dout_r;
    logic             dout_valid_r;
    logic             sync_err_r;

    logic             misalign_s;
    logic             cap_en_s;
    logic [SEL_W-1:0] sel_s;
    logic             sync_err_s;
    logic [N_CH-1:0]  we_s;
    logic             frame_done_s;

    // A sync seen mid-frame restarts the frame at slot 0 without leaving RUN.
    assign misalign_s = en && (state_r == RUN) && frame_sync && (slot_r != 4'd0);

    // The last slot is never stored: its strobe completes the frame with din taken live.
    assign frame_done_s = we_s[N_CH-1];

    // State and slot counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= HUNT;
            slot_r  <= 4'd0;
        end else begin
            state_r <= state_s;
            slot_r  <= slot_s;
        end
    end

    // Next state and slot: lock on sync, then free-run modulo 16.
    always_comb begin
        state_s = state_r;
        slot_s  = slot_r;
        if (en) begin
            case (state_r)
                HUNT: begin
                    if (frame_sync) begin
                        state_s = RUN;
                        slot_s  = 4'd1;
                    end else begin
                        state_s = HUNT;
                        slot_s  = 4'd0;
                    end
                end
                RUN: begin
                    state_s = RUN;
                    if (misalign_s) begin
                        slot_s = 4'd1;
                    end else begin
                        slot_s = slot_r + 4'd1;
                    end
                end
                default: begin
                    state_s = HUNT;
                    slot_s  = 4'd0;
                end
            endcase
        end else begin
            state_s = state_r;
            slot_s  = slot_r;
        end
    end

    // Capture select and error strobe derived from the current state.
    always_comb begin
        cap_en_s   = 1'b0;
        sel_s      = slot_r;
        sync_err_s = 1'b0;
        if (en) begin
            case (state_r)
                HUNT: begin
                    cap_en_s = frame_sync;
                    sel_s    = 4'd0;
                end
                RUN: begin
                    cap_en_s = 1'b1;
                    if (misalign_s) begin
                        sel_s      = 4'd0;
                        sync_err_s = 1'b1;
                    end else begin
                        sel_s      = slot_r;
                        sync_err_s = 1'b0;
                    end
                end
                default: begin
                    cap_en_s = 1'b0;
                    sel_s    = 4'd0;
                end
            endcase
        end else begin
            cap_en_s   = 1'b0;
            sel_s      = slot_r;
            sync_err_s = 1'b0;
        end
    end

    demux_1x16 u_demux (
        .sel (sel_s),
        .en  (cap_en_s),
        .we  (we_s)
    );

    // Per-channel capture flops for slots 0..14.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_r <= {(N_CH-1){1'b0}};
        end else begin
            cap_r <= (cap_r & ~we_s[N_CH-2:0]) | (we_s[N_CH-2:0] & {(N_CH-1){din}});
        end
    end

    // Output word and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_r       <= {N_CH{1'b0}};
            dout_valid_r <= 1'b0;
            sync_err_r   <= 1'b0;
        end else begin
            if (frame_done_s) begin
                dout_r <= {din, cap_r};
            end else begin
                dout_r <= dout_r;
            end
            dout_valid_r <= frame_done_s;
            sync_err_r   <= sync_err_s;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign slot       = slot_r;
    assign locked     = (state_r == RUN);
    assign sync_err   = sync_err_r;

endmodule

// File: tb/tb_tdm_demux16.sv
// Self-checking bench for tdm_demux16: directed scenarios followed by random traffic,
// all compared against a bit-position reference model of the TDM frame rules.
module tb_tdm_demux16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        din = 1'b0;
    logic        frame_sync = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic [3:0]  slot;
    logic        locked;
    logic        sync_err;

    int checks = 0;
    int errors = 0;

    // Reference model: lock flag, next bit position and the word being assembled
    bit          m_locked = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_word = 16'h0000;
    logic [15:0] m_dout = 16'h0000;

    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid = -1;
    int last_gap = 0;

    tdm_demux16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .din        (din),
        .frame_sync (frame_sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock: drive inputs, advance the model, then compare every output.
    task automatic step(input logic r, input logic e, input logic d, input logic f);
        logic ev;
        logic ee;
        @(negedge clk);
        rst_n      = r;
        en         = e;
        din        = d;
        frame_sync = f;
        ev = 1'b0;
        ee = 1'b0;
        if (!r) begin
            m_locked = 1'b0;
            m_pos    = 0;
            m_word   = 16'h0000;
            m_dout   = 16'h0000;
        end else if (e) begin
            if (!m_locked) begin
                if (f) begin
                    m_locked  = 1'b1;
                    m_word    = 16'h0000;
                    m_word[0] = d;
                    m_pos     = 1;
                end
            end else if (f && m_pos != 0) begin
                ee        = 1'b1;
                m_word    = 16'h0000;
                m_word[0] = d;
                m_pos     = 1;
            end else begin
                m_word[m_pos] = d;
                m_pos = m_pos + 1;
                if (m_pos == 16) begin
                    m_dout = m_word;
                    ev     = 1'b1;
                    m_pos  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("dout", dout, m_dout);
        check("dout_valid", {15'd0, dout_valid}, {15'd0, ev});
        check("slot", {12'd0, slot}, {12'd0, 4'(m_pos)});
        check("locked", {15'd0, locked}, {15'd0, m_locked});
        check("sync_err", {15'd0, sync_err}, {15'd0, ee});
        if (dout_valid) begin
            valid_cnt++;
            if (last_valid >= 0) last_gap = cyc - last_valid;
            last_valid = cyc;
        end
        if (sync_err) err_cnt++;
    endtask

    task automatic send_frame(input logic [15:0] w, input bit sync, input bit gap);
        for (int i = 0; i < 16; i++) begin
            if (gap) step(1'b1, 1'b0, rbit(), rbit());
            step(1'b1, 1'b1, w[i], (sync && i == 0) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        // 1: reset held with random inputs
        for (int i = 0; i < 3; i++) step(1'b0, rbit(), rbit(), rbit());
        check("rst_dout", dout, 16'h0000);
        check("rst_locked", {15'd0, locked}, 16'h0000);

        // 2: basic frame locked by sync
        valid_cnt = 0;
        send_frame(16'hA5C3, 1'b1, 1'b0);
        check("basic_dout", dout, 16'hA5C3);
        check("basic_slot", {12'd0, slot}, 16'h0000);
        step(1'b1, 1'b0, rbit(), 1'b0);
        check_int("basic_pulses", valid_cnt, 1);

        // 3: flywheel over three back-to-back frames
        valid_cnt = 0; err_cnt = 0; last_valid = -1; last_gap = 0;
        send_frame(16'h0001, 1'b1, 1'b0);
        check("fly_dout0", dout, 16'h0001);
        send_frame(16'h8000, 1'b0, 1'b0);
        check("fly_dout1", dout, 16'h8000);
        send_frame(16'hFFFF, 1'b0, 1'b0);
        check("fly_dout2", dout, 16'hFFFF);
        check_int("fly_pulses", valid_cnt, 3);
        check_int("fly_gap", last_gap, 16);
        check_int("fly_sync_err", err_cnt, 0);

        // 4: en low every other cycle
        valid_cnt = 0;
        send_frame(16'h1234, 1'b0, 1'b1);
        check("gap_dout", dout, 16'h1234);
        check_int("gap_pulses", valid_cnt, 1);

        // 5: sync arriving at slot 7
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, rbit(), 1'b0);
        check("mis_slot7", {12'd0, slot}, 16'h0007);
        valid_cnt = 0; err_cnt = 0;
        send_frame(16'h00FF, 1'b1, 1'b0);
        check_int("mis_err_pulses", err_cnt, 1);
        check_int("mis_valid_pulses", valid_cnt, 1);
        check("mis_dout", dout, 16'h00FF);

        // 6: reset at slot 9, then unsynced bits are ignored
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, rbit(), 1'b0);
        step(1'b0, rbit(), rbit(), rbit());
        check("midrst_dout", dout, 16'h0000);
        valid_cnt = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, rbit(), 1'b0);
        check_int("midrst_pulses", valid_cnt, 0);
        check("midrst_locked", {15'd0, locked}, 16'h0000);

        // 7: random traffic with occasional syncs and resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 rbit(),
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
